kmeans_centroid_update: RTL and testbench

KMEANS_CENTROID_UPDATE -- requirements
Module: kmeans_centroid_update

---
 rtl/kmeans_centroid_update.sv | 132 +++++++++++++
 tb/tb_kmeans_centroid_update.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/kmeans_centroid_update.sv
// K-means centroid update: per-cluster accumulate, floor-mean and convergence check on compute_mean; one-cycle mean_valid latency.
// No backpressure: one point per cycle always accepted; colliding or overflowing points are dropped and flagged on err.
module kmeans_centroid_update #(
  parameter int K        = 4,
  parameter int DW       = 8,
  parameter int THRESH   = 0,
  parameter int MAX_ITER = 16,
  localparam int IW      = (K > 1) ? $clog2(K) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid,
  input  logic [DW-1:0]   point_x,
  input  logic [DW-1:0]   point_y,
  input  logic [IW-1:0]   cluster_id,
  input  logic            compute_mean,
  input  logic            clear_acc,
  input  logic            init_we,
  input  logic [IW-1:0]   init_idx,
  input  logic [DW-1:0]   init_x,
  input  logic [DW-1:0]   init_y,
  output logic [K*DW-1:0] centroid_x,
  output logic [K*DW-1:0] centroid_y,
  output logic            converged,
  output logic            mean_valid,
  output logic [7:0]      iter_cnt,
  output logic            err
);

  localparam int SW = DW + 8;
  localparam logic [DW-1:0] THR = DW'(THRESH);
  localparam logic [7:0]    MAXI = 8'(MAX_ITER);

  logic [DW-1:0] cx [K];
  logic [DW-1:0] cy [K];
  logic [SW-1:0] sx [K];
  logic [SW-1:0] sy [K];
  logic [7:0]    cnt [K];

  logic [DW-1:0] new_x [K];
  logic [DW-1:0] new_y [K];
  logic [SW-1:0] qx, qy;
  logic [DW-1:0] dx, dy;
  logic          conv_all, conv_next;

  for (genvar g = 0; g < K; g++) begin : g_pack
    assign centroid_x[g*DW +: DW] = cx[g];
    assign centroid_y[g*DW +: DW] = cy[g];
  end

  // Empty clusters keep their centroid, so they always count as settled.
  always_comb begin
    new_x    = cx;
    new_y    = cy;
    conv_all = 1'b1;
    qx       = '0;
    qy       = '0;
    dx       = '0;
    dy       = '0;
    for (int k = 0; k < K; k++) begin
      if (cnt[k] != 8'd0) begin
        qx       = sx[k] / {{DW{1'b0}}, cnt[k]};
        qy       = sy[k] / {{DW{1'b0}}, cnt[k]};
        new_x[k] = qx[DW-1:0];
        new_y[k] = qy[DW-1:0];
      end
      dx = (new_x[k] > cx[k]) ? new_x[k] - cx[k] : cx[k] - new_x[k];
      dy = (new_y[k] > cy[k]) ? new_y[k] - cy[k] : cy[k] - new_y[k];
      if (dx > THR || dy > THR) conv_all = 1'b0;
    end
    conv_next = conv_all || ((iter_cnt + 8'd1) == MAXI);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < K; k++) begin
        cx[k]  <= '0;
        cy[k]  <= '0;
        sx[k]  <= '0;
        sy[k]  <= '0;
        cnt[k] <= '0;
      end
      converged  <= 1'b0;
      mean_valid <= 1'b0;
      iter_cnt   <= '0;
      err        <= 1'b0;
    end else begin
      mean_valid <= 1'b0;
      if (init_we) begin
        cx[init_idx] <= init_x;
        cy[init_idx] <= init_y;
        for (int k = 0; k < K; k++) begin
          sx[k]  <= '0;
          sy[k]  <= '0;
          cnt[k] <= '0;
        end
        iter_cnt  <= '0;
        converged <= 1'b0;
        // A point arriving with the load is still a dropped sample.
        err       <= valid;
      end else if (clear_acc) begin
        for (int k = 0; k < K; k++) begin
          sx[k]  <= '0;
          sy[k]  <= '0;
          cnt[k] <= '0;
        end
        if (valid) err <= 1'b1;
      end else if (compute_mean) begin
        for (int k = 0; k < K; k++) begin
          cx[k]  <= new_x[k];
          cy[k]  <= new_y[k];
          sx[k]  <= '0;
          sy[k]  <= '0;
          cnt[k] <= '0;
        end
        converged  <= conv_next;
        iter_cnt   <= conv_next ? 8'd0 : iter_cnt + 8'd1;
        mean_valid <= 1'b1;
        if (valid) err <= 1'b1;
      end else if (valid) begin
        if (cnt[cluster_id] == 8'hFF) begin
          err <= 1'b1;
        end else begin
          sx[cluster_id]  <= sx[cluster_id] + {8'd0, point_x};
          sy[cluster_id]  <= sy[cluster_id] + {8'd0, point_y};
          cnt[cluster_id] <= cnt[cluster_id] + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_kmeans_centroid_update.sv
// Directed bench for kmeans_centroid_update: default instance plus a MAX_ITER=2 instance on shared stimulus.
module tb_kmeans_centroid_update;

  logic        clk = 1'b0;
  logic        rst_n, valid, compute_mean, clear_acc, init_we;
  logic [7:0]  point_x, point_y, init_x, init_y;
  logic [1:0]  cluster_id, init_idx;
  logic [31:0] cx, cy, cx2, cy2;
  logic        conv, mv, err, conv2, mv2, err2;
  logic [7:0]  iter, iter2;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  kmeans_centroid_update dut (
    .clk(clk), .rst_n(rst_n), .valid(valid), .point_x(point_x), .point_y(point_y),
    .cluster_id(cluster_id), .compute_mean(compute_mean), .clear_acc(clear_acc),
    .init_we(init_we), .init_idx(init_idx), .init_x(init_x), .init_y(init_y),
    .centroid_x(cx), .centroid_y(cy), .converged(conv), .mean_valid(mv),
    .iter_cnt(iter), .err(err));

  kmeans_centroid_update #(.MAX_ITER(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .valid(valid), .point_x(point_x), .point_y(point_y),
    .cluster_id(cluster_id), .compute_mean(compute_mean), .clear_acc(clear_acc),
    .init_we(init_we), .init_idx(init_idx), .init_x(init_x), .init_y(init_y),
    .centroid_x(cx2), .centroid_y(cy2), .converged(conv2), .mean_valid(mv2),
    .iter_cnt(iter2), .err(err2));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic feed(input int c, input int x, input int y);
    cluster_id = 2'(c);
    point_x    = 8'(x);
    point_y    = 8'(y);
    valid      = 1'b1;
    tick();
    valid      = 1'b0;
  endtask

  task automatic load(input int c, input int x, input int y);
    init_idx = 2'(c);
    init_x   = 8'(x);
    init_y   = 8'(y);
    init_we  = 1'b1;
    tick();
    init_we  = 1'b0;
  endtask

  task automatic do_mean;
    compute_mean = 1'b1;
    tick();
    compute_mean = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; valid = 1'b1; compute_mean = 1'b0; clear_acc = 1'b0; init_we = 1'b0;
    point_x = 8'd9; point_y = 8'd9; cluster_id = 2'd0;
    init_x = 8'd0; init_y = 8'd0; init_idx = 2'd0;
    tick();
    chk("rst_cx", cx, 32'h0);
    chk("rst_cy", cy, 32'h0);
    chk("rst_conv", {31'd0, conv}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_iter", {24'd0, iter}, 32'd0);
    chk("rst_mv", {31'd0, mv}, 32'd0);
    valid = 1'b0;
    rst_n = 1'b1;

    load(0, 0, 0); load(1, 100, 100); load(2, 200, 200); load(3, 50, 50);
    chk("init_cx", cx, {8'd50, 8'd200, 8'd100, 8'd0});
    chk("init_cy", cy, {8'd50, 8'd200, 8'd100, 8'd0});

    feed(0, 10, 20); feed(0, 12, 22); feed(0, 14, 24);
    do_mean();
    chk("p1_mv", {31'd0, mv}, 32'd1);
    chk("p1_cx", cx, {8'd50, 8'd200, 8'd100, 8'd12});
    chk("p1_cy", cy, {8'd50, 8'd200, 8'd100, 8'd22});
    chk("p1_conv", {31'd0, conv}, 32'd0);
    chk("p1_iter", {24'd0, iter}, 32'd1);
    tick();
    chk("p1_mv_drop", {31'd0, mv}, 32'd0);
    chk("p1_hold_cx", cx, {8'd50, 8'd200, 8'd100, 8'd12});

    clear_acc = 1'b1; tick(); clear_acc = 1'b0;
    chk("clr_iter", {24'd0, iter}, 32'd1);
    feed(0, 10, 20); feed(0, 12, 22); feed(0, 14, 24);
    do_mean();
    chk("p2_cx", cx, {8'd50, 8'd200, 8'd100, 8'd12});
    chk("p2_conv", {31'd0, conv}, 32'd1);
    chk("p2_iter", {24'd0, iter}, 32'd0);
    chk("p2_err", {31'd0, err}, 32'd0);

    feed(1, 1, 1); feed(1, 2, 2);
    do_mean();
    chk("floor_cx", cx, {8'd50, 8'd200, 8'd1, 8'd12});
    chk("floor_cy", cy, {8'd50, 8'd200, 8'd1, 8'd22});
    chk("floor_conv", {31'd0, conv}, 32'd0);
    chk("floor_iter", {24'd0, iter}, 32'd1);

    feed(3, 60, 60);
    cluster_id = 2'd3; point_x = 8'd255; point_y = 8'd255; valid = 1'b1;
    do_mean();
    valid = 1'b0;
    chk("coll_cx", cx, {8'd60, 8'd200, 8'd1, 8'd12});
    chk("coll_err", {31'd0, err}, 32'd1);
    chk("coll_iter", {24'd0, iter}, 32'd2);
    tick(); tick();
    clear_acc = 1'b1; tick(); clear_acc = 1'b0;
    chk("coll_err_sticky", {31'd0, err}, 32'd1);
    feed(1, 90, 90);
    clear_acc = 1'b1; tick(); clear_acc = 1'b0;
    do_mean();
    chk("clr_keep_cx", cx, {8'd60, 8'd200, 8'd1, 8'd12});
    load(0, 12, 22);
    chk("init_err_clr", {31'd0, err}, 32'd0);
    chk("init_iter_clr", {24'd0, iter}, 32'd0);
    chk("init_conv_clr", {31'd0, conv}, 32'd0);

    for (int i = 0; i < 255; i++) feed(0, 7, 9);
    chk("sat_no_err", {31'd0, err}, 32'd0);
    feed(0, 200, 200);
    chk("sat_err", {31'd0, err}, 32'd1);
    do_mean();
    chk("sat_cx", cx, {8'd60, 8'd200, 8'd1, 8'd7});
    chk("sat_cy", cy, {8'd60, 8'd200, 8'd1, 8'd9});

    feed(0, 250, 250);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk("rst2_cx", cx2, 32'h0);
    chk("rst2_err", {31'd0, err}, 32'd0);
    feed(0, 10, 10);
    do_mean();
    chk("capA_cx", cx2, {8'd0, 8'd0, 8'd0, 8'd10});
    chk("capA_conv", {31'd0, conv2}, 32'd0);
    chk("capA_iter", {24'd0, iter2}, 32'd1);
    feed(0, 20, 20);
    do_mean();
    chk("capB_cx", cx2, {8'd0, 8'd0, 8'd0, 8'd20});
    chk("capB_mv", {31'd0, mv2}, 32'd1);
    chk("capB_conv", {31'd0, conv2}, 32'd1);
    chk("capB_iter", {24'd0, iter2}, 32'd0);
    chk("nocap_conv", {31'd0, conv}, 32'd0);
    chk("nocap_iter", {24'd0, iter}, 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
